// File: rtl/rv_decode_pkg.sv
// Shared decode definitions for the RV32/RV64 decode stage: opcodes, class enum,
// control-bit layout, decode bundle and the field/control decoder.
package rv_decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    CLS_R       = 4'd0,
    CLS_OPIMM   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd15
  } opcls_e;

  // out_ctrl = {MemRead, MemToReg, MemWrite, ALUSrc, RegWrite, branch, jal_sel, jalr_sel}
  localparam int CTRL_MEMREAD  = 7;
  localparam int CTRL_MEMTOREG = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_ALUSRC   = 4;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_JAL      = 1;
  localparam int CTRL_JALR     = 0;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [2:0] func3;
    logic [6:0] func7;
    opcls_e     opcls;
    logic [7:0] ctrl;
    logic       illegal;
  } dec_bundle_t;

  function automatic dec_bundle_t decode_instr(input logic [31:0] instr, input logic rv32);
    dec_bundle_t b;
    logic [7:0]  c;
    b.rs1     = instr[19:15];
    b.rs2     = instr[24:20];
    b.rd      = instr[11:7];
    b.func3   = instr[14:12];
    b.func7   = instr[31:25];
    b.illegal = 1'b0;
    b.opcls   = CLS_ILLEGAL;
    c         = '0;
    case (instr[6:0])
      OP_R:      begin b.opcls = CLS_R;      c[CTRL_REGWRITE] = 1'b1; end
      OP_OPIMM:  begin b.opcls = CLS_OPIMM;  c[CTRL_ALUSRC] = 1'b1; c[CTRL_REGWRITE] = 1'b1; end
      OP_LOAD:   begin
        b.opcls = CLS_LOAD;
        c[CTRL_MEMREAD]  = 1'b1;
        c[CTRL_MEMTOREG] = 1'b1;
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
      end
      OP_STORE:  begin b.opcls = CLS_STORE;  c[CTRL_MEMWRITE] = 1'b1; c[CTRL_ALUSRC] = 1'b1; end
      OP_BRANCH: begin b.opcls = CLS_BRANCH; c[CTRL_BRANCH] = 1'b1; end
      OP_JAL:    begin b.opcls = CLS_JAL;    c[CTRL_JAL] = 1'b1; c[CTRL_REGWRITE] = 1'b1; end
      OP_JALR:   begin
        b.opcls = CLS_JALR;
        c[CTRL_JALR]     = 1'b1;
        c[CTRL_ALUSRC]   = 1'b1;
        c[CTRL_REGWRITE] = 1'b1;
      end
      OP_LUI:    begin b.opcls = CLS_LUI;    c[CTRL_ALUSRC] = 1'b1; c[CTRL_REGWRITE] = 1'b1; end
      OP_AUIPC:  begin b.opcls = CLS_AUIPC;  c[CTRL_ALUSRC] = 1'b1; c[CTRL_REGWRITE] = 1'b1; end
      default:   b.illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11)
      b.illegal = 1'b1;
    // Doubleword load/store does not exist on RV32
    if (rv32 && (b.opcls == CLS_LOAD || b.opcls == CLS_STORE) && instr[14:12] == 3'b011)
      b.illegal = 1'b1;
    if (b.illegal) begin
      b.opcls = CLS_ILLEGAL;
      c       = '0;
    end
    b.ctrl = c;
    return b;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate generator; sign bit always comes from instr[31] of the
// instruction being decoded, and illegal encodings produce a zero immediate.
module rv_imm_gen
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]             instr,
  input  opcls_e                  opcls,
  output logic signed [XLEN-1:0]  imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (opcls)
      CLS_OPIMM, CLS_LOAD, CLS_JALR:
        imm32 = {{20{instr[31]}}, instr[31:20]};
      CLS_STORE:
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      CLS_BRANCH:
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      CLS_JAL:
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      CLS_LUI, CLS_AUIPC:
        imm32 = {instr[31:12], 12'b0};
      default:
        imm32 = '0;
    endcase
  end

  // Signed cast sign-extends to XLEN; a no-op when XLEN is 32
  assign imm = XLEN'(imm32);

endmodule

// File: rtl/rv_decode_stage.sv
// RV32/RV64 decode pipeline stage with valid/ready on both sides and a one-entry
// skid buffer so in_ready is registered. Optional counters: define DECODE_PERF_EN.
module rv_decode_stage
  import rv_decode_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = XLEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [31:0]            in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_W-1:0]        out_pc,
  output logic signed [XLEN-1:0] out_imm,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [4:0]             out_rd,
  output logic [2:0]             out_func3,
  output logic [6:0]             out_func7,
  output logic [3:0]             out_opcls,
  output logic [7:0]             out_ctrl,
  output logic                   out_illegal
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]            perf_decoded,
  output logic [31:0]            perf_illegal,
  output logic [31:0]            perf_stall
`endif
);

  localparam logic RV32 = (XLEN == 32);

  dec_bundle_t            dec_in;
  logic signed [XLEN-1:0] imm_in;

  dec_bundle_t            dec_p0, dec_p1;
  logic signed [XLEN-1:0] imm_p0, imm_p1;
  logic [PC_W-1:0]        pc_p0, pc_p1;
  logic                   vld_p0, vld_p1;

  logic in_fire, out_fire, main_free;

  assign dec_in = decode_instr(in_instr, RV32);

  rv_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr),
    .opcls (dec_in.opcls),
    .imm   (imm_in)
  );

  assign in_ready  = ~vld_p0;
  assign in_fire   = in_valid & ~vld_p0;
  assign out_fire  = vld_p1 & out_ready;
  assign main_free = ~vld_p1 | out_ready;

  // Stage p0 = skid entry (later arrival), p1 = main entry driving the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      dec_p0 <= '0;
      imm_p0 <= '0;
      pc_p0  <= '0;
      dec_p1 <= '0;
      imm_p1 <= '0;
      pc_p1  <= '0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (main_free) begin
      if (vld_p0) begin
        dec_p1 <= dec_p0;
        imm_p1 <= imm_p0;
        pc_p1  <= pc_p0;
        vld_p1 <= 1'b1;
        vld_p0 <= 1'b0;
      end else if (in_fire) begin
        dec_p1 <= dec_in;
        imm_p1 <= imm_in;
        pc_p1  <= in_pc;
        vld_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (in_fire) begin
      dec_p0 <= dec_in;
      imm_p0 <= imm_in;
      pc_p0  <= in_pc;
      vld_p0 <= 1'b1;
    end
  end

  // Output boundary: main register drives the bundle directly
  assign out_valid   = vld_p1;
  assign out_pc      = pc_p1;
  assign out_imm     = imm_p1;
  assign out_rs1     = dec_p1.rs1;
  assign out_rs2     = dec_p1.rs2;
  assign out_rd      = dec_p1.rd;
  assign out_func3   = dec_p1.func3;
  assign out_func7   = dec_p1.func7;
  assign out_opcls   = dec_p1.opcls;
  assign out_ctrl    = dec_p1.ctrl;
  assign out_illegal = dec_p1.illegal;

`ifdef DECODE_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  // Counters observe the output port only and deliberately ignore flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_decoded <= '0;
      perf_illegal <= '0;
      perf_stall   <= '0;
    end else begin
      perf_decoded <= sat_inc(perf_decoded, out_fire);
      perf_illegal <= sat_inc(perf_illegal, out_fire & dec_p1.illegal);
      perf_stall   <= sat_inc(perf_stall, vld_p1 & ~out_ready);
    end
  end
`else
  logic unused_fire;
  assign unused_fire = out_fire;
`endif

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: decode table on RV64 and RV32 instances,
// plus backpressure, flush and asynchronous-reset sequences.
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;

  logic        in_ready, out_valid, out_illegal;
  logic [63:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_func3;
  logic [6:0]  out_func7;
  logic [3:0]  out_opcls;
  logic [7:0]  out_ctrl;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_pc32, out_imm32;
  logic [4:0]  out_rs1_32, out_rs2_32, out_rd_32;
  logic [2:0]  out_func3_32;
  logic [6:0]  out_func7_32;
  logic [3:0]  out_opcls32;
  logic [7:0]  out_ctrl32;

`ifdef DECODE_PERF_EN
  logic [31:0] perf_decoded, perf_illegal, perf_stall;
  logic [31:0] perf_decoded32, perf_illegal32, perf_stall32;
  logic [31:0] snap_stall, snap_dec;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_func3(out_func3), .out_func7(out_func7), .out_opcls(out_opcls),
    .out_ctrl(out_ctrl), .out_illegal(out_illegal)
`ifdef DECODE_PERF_EN
    , .perf_decoded(perf_decoded), .perf_illegal(perf_illegal), .perf_stall(perf_stall)
`endif
  );

  rv_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_pc(in_pc[31:0]), .in_instr(in_instr),
    .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32), .out_imm(out_imm32),
    .out_rs1(out_rs1_32), .out_rs2(out_rs2_32), .out_rd(out_rd_32),
    .out_func3(out_func3_32), .out_func7(out_func7_32), .out_opcls(out_opcls32),
    .out_ctrl(out_ctrl32), .out_illegal(out_illegal32)
`ifdef DECODE_PERF_EN
    , .perf_decoded(perf_decoded32), .perf_illegal(perf_illegal32), .perf_stall(perf_stall32)
`endif
  );

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [63:0] imm;
    logic [3:0]  opcls;
    logic [7:0]  ctrl;
    logic        ill;
    logic        ill32;
    logic [7:0]  ctrl32;
    logic [31:0] imm32;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [63:0] pc);
    @(negedge clk);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF30293, 5'd5,  5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1,  8'h18, 1'b0, 1'b0, 8'h18, 32'hFFFF_FFFF};
    vecs[1]  = '{32'h00713423, 5'd8,  5'd2, 64'h8,                   4'd3,  8'h30, 1'b0, 1'b1, 8'h00, 32'h0};
    vecs[2]  = '{32'hFE000EE3, 5'd29, 5'd0, 64'hFFFF_FFFF_FFFF_FFFC, 4'd4,  8'h04, 1'b0, 1'b0, 8'h04, 32'hFFFF_FFFC};
    vecs[3]  = '{32'h001000EF, 5'd1,  5'd0, 64'h800,                 4'd5,  8'h0A, 1'b0, 1'b0, 8'h0A, 32'h800};
    vecs[4]  = '{32'h00000000, 5'd0,  5'd0, 64'h0,                   4'd15, 8'h00, 1'b1, 1'b1, 8'h00, 32'h0};
    vecs[5]  = '{32'h80000537, 5'd10, 5'd0, 64'hFFFF_FFFF_8000_0000, 4'd7,  8'h18, 1'b0, 1'b0, 8'h18, 32'h8000_0000};
    vecs[6]  = '{32'hFF823183, 5'd3,  5'd4, 64'hFFFF_FFFF_FFFF_FFF8, 4'd2,  8'hD8, 1'b0, 1'b1, 8'h00, 32'h0};
    vecs[7]  = '{32'hFF822183, 5'd3,  5'd4, 64'hFFFF_FFFF_FFFF_FFF8, 4'd2,  8'hD8, 1'b0, 1'b0, 8'hD8, 32'hFFFF_FFF8};
    vecs[8]  = '{32'h000280E7, 5'd1,  5'd5, 64'h0,                   4'd6,  8'h19, 1'b0, 1'b0, 8'h19, 32'h0};
    vecs[9]  = '{32'h003100B3, 5'd1,  5'd2, 64'h0,                   4'd0,  8'h08, 1'b0, 1'b0, 8'h08, 32'h0};
    vecs[10] = '{32'h12345117, 5'd2,  5'd8, 64'h1234_5000,           4'd8,  8'h18, 1'b0, 1'b0, 8'h18, 32'h1234_5000};
    vecs[11] = '{32'h00000291, 5'd5,  5'd0, 64'h0,                   4'd15, 8'h00, 1'b1, 1'b1, 8'h00, 32'h0};
    vecs[12] = '{32'h00712423, 5'd8,  5'd2, 64'h8,                   4'd3,  8'h30, 1'b0, 1'b0, 8'h30, 32'h8};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_instr = '0;
    tick(); tick();
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_imm",   out_imm,        64'd0);
    chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back decode table, downstream always ready
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].instr, 64'h1000 + 64'(4 * i));
      tick();
      chk($sformatf("v%0d_valid", i),   64'(out_valid),   64'd1);
      chk($sformatf("v%0d_pc", i),      out_pc,           64'h1000 + 64'(4 * i));
      chk($sformatf("v%0d_rd", i),      64'(out_rd),      64'(vecs[i].rd));
      chk($sformatf("v%0d_rs1", i),     64'(out_rs1),     64'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2", i),     64'(out_rs2),     64'(vecs[i].instr[24:20]));
      chk($sformatf("v%0d_func3", i),   64'(out_func3),   64'(vecs[i].instr[14:12]));
      chk($sformatf("v%0d_func7", i),   64'(out_func7),   64'(vecs[i].instr[31:25]));
      chk($sformatf("v%0d_imm", i),     out_imm,          vecs[i].imm);
      chk($sformatf("v%0d_opcls", i),   64'(out_opcls),   64'(vecs[i].opcls));
      chk($sformatf("v%0d_ctrl", i),    64'(out_ctrl),    64'(vecs[i].ctrl));
      chk($sformatf("v%0d_illegal", i), 64'(out_illegal), 64'(vecs[i].ill));
      chk($sformatf("v%0d_ill32", i),   64'(out_illegal32), 64'(vecs[i].ill32));
      chk($sformatf("v%0d_ctrl32", i),  64'(out_ctrl32),  64'(vecs[i].ctrl32));
      chk($sformatf("v%0d_imm32", i),   64'(out_imm32),   64'(vecs[i].imm32));
    end
    drive(1'b0, 32'h0, 64'h0);
    tick();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: A to main, B to skid, C waits; release yields A, B, C in order
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF30293, 64'hA0);
    tick();
    chk("bp_a_valid", 64'(out_valid), 64'd1);
    chk("bp_a_ready", 64'(in_ready),  64'd1);
`ifdef DECODE_PERF_EN
    snap_stall = perf_stall;
    snap_dec   = perf_decoded;
`endif
    drive(1'b1, 32'h80000537, 64'hB0);
    tick();
    chk("bp_b_ready", 64'(in_ready), 64'd0);
    chk("bp_b_hold",  out_pc,        64'hA0);
    drive(1'b1, 32'h12345117, 64'hC0);
    tick();
    chk("bp_c_ready", 64'(in_ready), 64'd0);
    chk("bp_c_hold",  64'(out_rd),   64'd5);
    @(negedge clk);
    out_ready = 1'b1;
    tick();
    chk("bp_rel_b_pc", out_pc,        64'hB0);
    chk("bp_rel_b_rd", 64'(out_rd),   64'd10);
    chk("bp_rel_rdy",  64'(in_ready), 64'd1);
    tick();
    chk("bp_rel_c_pc", out_pc,         64'hC0);
    chk("bp_rel_c_v",  64'(out_valid), 64'd1);
    drive(1'b0, 32'h0, 64'h0);
    tick();
    chk("bp_end_valid", 64'(out_valid), 64'd0);
`ifdef DECODE_PERF_EN
    chk("perf_stall_delta",   64'(perf_stall - snap_stall), 64'd2);
    chk("perf_decoded_delta", 64'(perf_decoded - snap_dec), 64'd3);
`endif

    // Flush with both entries full, then flush while in_ready=1 with a new input
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF30293, 64'h200);
    tick();
    drive(1'b1, 32'h003100B3, 64'h204);
    tick();
    chk("fl_full_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h001000EF; in_pc = 64'h208;
    tick();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready),  64'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl_after_valid", 64'(out_valid), 64'd0);
    drive(1'b1, 32'h80000537, 64'h300);
    tick();
    chk("fl_d_valid", 64'(out_valid), 64'd1);
    chk("fl_d_rd",    64'(out_rd),    64'd10);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h12345117; in_pc = 64'h304;
    tick();
    chk("fl2_valid", 64'(out_valid), 64'd0);
    chk("fl2_ready", 64'(in_ready),  64'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl2_discarded", 64'(out_valid), 64'd0);

    // Asynchronous reset mid-stall with both entries held
    out_ready = 1'b0;
    drive(1'b1, 32'hFFF30293, 64'h400);
    tick();
    drive(1'b1, 32'h00713423, 64'h404);
    tick();
    chk("ar_pre_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_ready", 64'(in_ready),  64'd1);
    chk("ar_imm",   out_imm,        64'd0);
    chk("ar_pc",    out_pc,         64'd0);
    chk("ar_ctrl",  64'(out_ctrl),  64'd0);
`ifdef DECODE_PERF_EN
    chk("ar_perf_stall", 64'(perf_stall), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    tick();
    chk("ar_post_valid", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
